// File: rtl/ysyx_bus_pkg.sv
// Shared types and helpers for the LSU store/load bus responder.
// Contents: response codes, slave FSM state type, strobe-width helper.
package ysyx_bus_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_R_LAT  = 3'd1,
        ST_R_RESP = 3'd2,
        ST_W_LAT  = 3'd3,
        ST_W_RESP = 3'd4
    } slave_state_e;

    // Number of byte lanes in an xlen-bit word.
    function automatic int unsigned strb_width(input int unsigned xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/ysyx_sram_array.sv
// Word-organised storage for the SRAM window, kept apart so a macro can replace it.
// Ports: clock; we/widx/wdata/wstrb byte-strobed write port;
//        ridx index and rdata_c combinational read data.
module ysyx_sram_array
    import ysyx_bus_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_WORDS = 2048,
    localparam int unsigned AW       = $clog2(MEM_WORDS),
    localparam int unsigned SW       = strb_width(XLEN)
) (
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   widx,
    input  logic [XLEN-1:0] wdata,
    input  logic [SW-1:0]   wstrb,
    input  logic [AW-1:0]   ridx,
    output logic [XLEN-1:0] rdata_c
);

    logic [XLEN-1:0] mem [MEM_WORDS];

    // Byte-lane write; contents intentionally have no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < int'(SW); i++) begin
                if (wstrb[i]) begin
                    mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[ridx];

endmodule

// File: rtl/ysyx_bus_sram_slave.sv
// Bus responder for the on-chip SRAM window: one transaction at a time,
// programmable read/write latency, DECERR outside the window.
// Ports: clock, reset (async, active low); read channel araddr/arvalid/arready,
//        rdata/rresp/rvalid/rready; write channel awaddr/awvalid/awready,
//        wdata/wstrb/wvalid/wready, bresp/bvalid/bready.
module ysyx_bus_sram_slave
    import ysyx_bus_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE      = XLEN'(32'h0f00_0000),
    parameter int unsigned     MEM_WORDS = 2048,
    parameter int unsigned     READ_LAT  = 2,
    parameter int unsigned     WRITE_LAT = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [XLEN-1:0]             araddr,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [XLEN-1:0]             rdata,
    output resp_t                       rresp,
    output logic                        rvalid,
    input  logic                        rready,
    input  logic [XLEN-1:0]             awaddr,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [XLEN-1:0]             wdata,
    input  logic [strb_width(XLEN)-1:0] wstrb,
    input  logic                        wvalid,
    output logic                        wready,
    output resp_t                       bresp,
    output logic                        bvalid,
    input  logic                        bready
);

    localparam int unsigned     SW        = strb_width(XLEN);
    localparam int unsigned     AW        = $clog2(MEM_WORDS);
    localparam int unsigned     CW        = 4;
    localparam logic [XLEN-1:0] WIN_BYTES = XLEN'(MEM_WORDS * 4);

    slave_state_e    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [SW-1:0]   strb_q, strb_d;
    logic            rvalid_d, bvalid_d;
    logic [XLEN-1:0] rdata_d;
    resp_t           rresp_d, bresp_d;

    logic            wr_go_c, rd_go_c;
    logic            enter_w_c, enter_r_c;
    logic [XLEN-1:0] cur_addr_c, off_c;
    logic            hit_c;
    logic [AW-1:0]   idx_c;
    logic [XLEN-1:0] wr_data_c, mem_rdata_c;
    logic [SW-1:0]   wr_strb_c;
    logic            mem_we_c;

    // Accept only in IDLE and never while reset is asserted; a paired write beats a read.
    assign wr_go_c = reset && (state_q == ST_IDLE) && awvalid && wvalid;
    assign rd_go_c = reset && (state_q == ST_IDLE) && arvalid && !(awvalid && wvalid);
    assign awready = wr_go_c;
    assign wready  = wr_go_c;
    assign arready = rd_go_c;

    // Zero-latency transactions commit straight from the bus inputs.
    assign cur_addr_c = (state_q != ST_IDLE) ? addr_q : (wr_go_c ? awaddr : araddr);
    assign wr_data_c  = (state_q == ST_IDLE) ? wdata : data_q;
    assign wr_strb_c  = (state_q == ST_IDLE) ? wstrb : strb_q;

    // Wrapping subtraction: addresses below BASE become huge and miss.
    assign off_c = cur_addr_c - BASE;
    assign hit_c = off_c < WIN_BYTES;
    assign idx_c = off_c[AW+1:2];

    ysyx_sram_array #(
        .XLEN      (XLEN),
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clock   (clock),
        .we      (mem_we_c),
        .widx    (idx_c),
        .wdata   (wr_data_c),
        .wstrb   (wr_strb_c),
        .ridx    (idx_c),
        .rdata_c (mem_rdata_c)
    );

    // Next-state, latency countdown and response generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        rvalid_d  = rvalid;
        rdata_d   = rdata;
        rresp_d   = rresp;
        bvalid_d  = bvalid;
        bresp_d   = bresp;
        enter_w_c = 1'b0;
        enter_r_c = 1'b0;
        mem_we_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_go_c) begin
                    addr_d = awaddr;
                    data_d = wdata;
                    strb_d = wstrb;
                    cnt_d  = CW'(WRITE_LAT);
                    if (WRITE_LAT == 0) enter_w_c = 1'b1;
                    else                state_d   = ST_W_LAT;
                end else if (rd_go_c) begin
                    addr_d = araddr;
                    cnt_d  = CW'(READ_LAT);
                    if (READ_LAT == 0) enter_r_c = 1'b1;
                    else               state_d   = ST_R_LAT;
                end
            end
            ST_W_LAT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) enter_w_c = 1'b1;
            end
            ST_R_LAT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) enter_r_c = 1'b1;
            end
            ST_W_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_R_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Memory is written exactly on W_RESP entry, so later reads see it.
        if (enter_w_c) begin
            state_d  = ST_W_RESP;
            mem_we_c = hit_c;
            bvalid_d = 1'b1;
            bresp_d  = hit_c ? RESP_OKAY : RESP_DECERR;
        end
        if (enter_r_c) begin
            state_d  = ST_R_RESP;
            rvalid_d = 1'b1;
            rdata_d  = hit_c ? mem_rdata_c : '0;
            rresp_d  = hit_c ? RESP_OKAY : RESP_DECERR;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            rvalid  <= rvalid_d;
            rdata   <= rdata_d;
            rresp   <= rresp_d;
            bvalid  <= bvalid_d;
            bresp   <= bresp_d;
        end
    end

endmodule

// File: tb/tb_ysyx_bus_sram_slave.sv
// Self-checking bench for ysyx_bus_sram_slave: directed cases plus randomized
// transactions against a byte-level memory model. Instance 0 uses
// READ_LAT=2/WRITE_LAT=1, instance 1 uses READ_LAT=2/WRITE_LAT=5.
module tb_ysyx_bus_sram_slave;

    localparam logic [31:0] BASE  = 32'h0f00_0000;
    localparam int          WORDS = 2048;
    localparam int          RL0   = 2;
    localparam int          WL0   = 1;
    localparam int          RL1   = 2;
    localparam int          WL1   = 5;

    logic        clock;
    logic        reset   [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];

    ysyx_bus_sram_slave #(.READ_LAT(RL0), .WRITE_LAT(WL0)) u_dut0 (
        .clock(clock), .reset(reset[0]),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
    );

    ysyx_bus_sram_slave #(.READ_LAT(RL1), .WRITE_LAT(WL1)) u_dut1 (
        .clock(clock), .reset(reset[1]),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference memory: word data plus per-byte "has been written" flags.
    logic [31:0] mem_m [2][WORDS];
    logic [3:0]  kb_m  [2][WORDS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int wlat(input int d);
        return (d == 0) ? WL0 : WL1;
    endfunction

    function automatic int rlat(input int d);
        return (d == 0) ? RL0 : RL1;
    endfunction

    function automatic bit hit_f(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(WORDS * 4);
    endfunction

    function automatic int idx_f(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2) % WORDS;
    endfunction

    // Write transaction. pre: address/data/valids already driven at this negedge.
    // with_ar: a read request is held alongside and must stay unaccepted.
    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] s, input int hold, input bit pre, input bit with_ar);
        int          cyc;
        logic [1:0]  br;
        int          k;
        if (!pre) begin
            @(negedge clock);
            awaddr[d] = a; wdata[d] = w; wstrb[d] = s;
            awvalid[d] = 1'b1; wvalid[d] = 1'b1;
        end
        #1;
        check("awready", awready[d], 1);
        check("wready", wready[d], 1);
        if (with_ar) check("ar_blocked", arready[d], 0);
        @(posedge clock);
        @(negedge clock);
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        cyc = 1;
        while (!bvalid[d] && cyc < 40) begin
            if (with_ar) check("ar_wait", arready[d], 0);
            @(negedge clock);
            cyc++;
        end
        check("b_latency", cyc, 1 + wlat(d));
        br = hit_f(a) ? 2'b00 : 2'b11;
        check("bresp", bresp[d], br);
        if (hit_f(a)) begin
            k = idx_f(a);
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    mem_m[d][k][i*8 +: 8] = w[i*8 +: 8];
                    kb_m[d][k][i] = 1'b1;
                end
            end
        end
        repeat (hold) begin
            @(negedge clock);
            check("bvalid_hold", bvalid[d], 1);
            check("bresp_hold", bresp[d], br);
            if (with_ar) check("ar_hold", arready[d], 0);
        end
        bready[d] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bready[d] = 1'b0;
        #1;
        check("bvalid_drop", bvalid[d], 0);
        if (with_ar) check("ar_after_b", arready[d], 1);
    endtask

    // Read transaction; returns the observed data word.
    task automatic do_read(input int d, input logic [31:0] a, input int hold, input bit pre,
                           output logic [31:0] got);
        int          cyc;
        int          k;
        logic [1:0]  rr;
        logic [31:0] mask;
        logic [31:0] exp;
        if (!pre) begin
            @(negedge clock);
            araddr[d] = a; arvalid[d] = 1'b1;
        end
        #1;
        check("arready", arready[d], 1);
        @(posedge clock);
        @(negedge clock);
        arvalid[d] = 1'b0;
        cyc = 1;
        while (!rvalid[d] && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check("r_latency", cyc, 1 + rlat(d));
        rr = hit_f(a) ? 2'b00 : 2'b11;
        check("rresp", rresp[d], rr);
        mask = 32'hffff_ffff;
        exp  = 32'h0;
        if (hit_f(a)) begin
            k = idx_f(a);
            exp = mem_m[d][k];
            for (int i = 0; i < 4; i++) if (!kb_m[d][k][i]) mask[i*8 +: 8] = 8'h00;
        end
        got = rdata[d];
        if (mask != 0) check("rdata", got & mask, exp & mask);
        repeat (hold) begin
            @(negedge clock);
            check("rvalid_hold", rvalid[d], 1);
            check("rresp_hold", rresp[d], rr);
            if (mask != 0) check("rdata_hold", rdata[d] & mask, exp & mask);
        end
        rready[d] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready[d] = 1'b0;
        #1;
        check("rvalid_drop", rvalid[d], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int          sel;

        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0;
            araddr[d] = '0; arvalid[d] = 1'b1; rready[d] = 1'b0;
            awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
            awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                mem_m[d][k] = '0;
                kb_m[d][k]  = '0;
            end
        end

        // Reset state, with requests pending to show readies are gated.
        repeat (3) @(negedge clock);
        #1;
        check("rst_arready", arready[0], 0);
        check("rst_awready", awready[0], 0);
        check("rst_wready", wready[0], 0);
        check("rst_rvalid", rvalid[0], 0);
        check("rst_bvalid", bvalid[0], 0);
        check("rst_rdata", rdata[0], 0);
        check("rst_rresp", rresp[0], 0);
        check("rst_bresp", bresp[0], 0);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            arvalid[d] = 1'b0; awvalid[d] = 1'b0; wvalid[d] = 1'b0;
            reset[d] = 1'b1;
        end

        // Basic write then read.
        do_write(0, 32'h0f00_0010, 32'hdead_beef, 4'hf, 0, 0, 0);
        do_read(0, 32'h0f00_0010, 0, 0, got);
        check("wr_rd_data", got, 32'hdead_beef);

        // Byte strobes.
        do_write(0, 32'h0f00_0020, 32'h1122_3344, 4'hf, 0, 0, 0);
        do_write(0, 32'h0f00_0020, 32'haabb_ccdd, 4'b0101, 1, 0, 0);
        do_read(0, 32'h0f00_0020, 0, 0, got);
        check("strobe_data", got, 32'h11bb_33dd);

        // Decode errors and window boundaries.
        do_read(0, 32'h0f00_2000, 1, 0, got);
        check("decerr_rdata", got, 32'h0);
        do_write(0, 32'h0eff_ffff, 32'h5555_5555, 4'hf, 0, 0, 0);
        do_read(0, 32'h0f00_0010, 0, 0, got);
        check("decerr_keep10", got, 32'hdead_beef);
        do_read(0, 32'h0f00_0020, 0, 0, got);
        check("decerr_keep20", got, 32'h11bb_33dd);
        do_write(0, 32'h0f00_1ffc, 32'h5a5a_0f0f, 4'hf, 0, 0, 0);
        do_read(0, 32'h0f00_1fff, 0, 0, got);
        check("last_word", got, 32'h5a5a_0f0f);
        do_write(0, 32'h0f00_0012, 32'hffff_ffff, 4'h0, 0, 0, 0);
        do_read(0, 32'h0f00_0010, 0, 0, got);
        check("zero_strb", got, 32'hdead_beef);

        // Collision: write wins, read waits through 5 cycles of bready low.
        @(negedge clock);
        araddr[0] = 32'h0f00_0030; arvalid[0] = 1'b1;
        awaddr[0] = 32'h0f00_0030; wdata[0] = 32'h0102_0304; wstrb[0] = 4'hf;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        do_write(0, 32'h0f00_0030, 32'h0102_0304, 4'hf, 5, 1, 1);
        do_read(0, 32'h0f00_0030, 0, 1, got);
        check("collide_raw", got, 32'h0102_0304);

        // Lone address channel is not accepted.
        @(negedge clock);
        awaddr[0] = 32'h0f00_0040; wdata[0] = 32'h7777_8888; wstrb[0] = 4'hf;
        awvalid[0] = 1'b1; wvalid[0] = 1'b0;
        repeat (4) begin
            #1;
            check("lone_awready", awready[0], 0);
            check("lone_wready", wready[0], 0);
            @(negedge clock);
        end
        wvalid[0] = 1'b1;
        do_write(0, 32'h0f00_0040, 32'h7777_8888, 4'hf, 0, 1, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 6)      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else if (sel == 7) a = BASE + 32'h1ffc + 32'($urandom_range(0, 3));
            else if (sel == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
            else               a = BASE + 32'h2000 + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(0, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0, 0);
            else
                do_read(0, a, int'($urandom_range(0, 3)), 0, got);
        end

        // Async reset in the middle of a long write latency.
        do_write(1, 32'h0f00_0040, 32'hcafe_f00d, 4'hf, 0, 0, 0);
        @(negedge clock);
        awaddr[1] = 32'h0f00_0040; wdata[1] = 32'h1234_5678; wstrb[1] = 4'hf;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        reset[1] = 1'b0;
        #1;
        check("mid_rst_bvalid", bvalid[1], 0);
        check("mid_rst_awready", awready[1], 0);
        check("mid_rst_wready", wready[1], 0);
        check("mid_rst_bresp", bresp[1], 0);
        @(negedge clock);
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        reset[1] = 1'b1;
        repeat (6) @(negedge clock);
        #1;
        check("post_rst_bvalid", bvalid[1], 0);
        do_read(1, 32'h0f00_0040, 0, 0, got);
        check("rst_no_write", got, 32'hcafe_f00d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
